// File: rtl/mc_connect_rr.sv
// N-client to single memory-controller interconnect: arbitrated, registered request stage,
// in-order responses routed back through a port-ID FIFO; request reaches the MC 1 cycle after accept.
module mc_connect_rr #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CONNECT_NUM     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [CONNECT_NUM-1:0]                    SLAVE_RECEIVE_ADDR_VALID,
  input  logic [ADDR_WIDTH*CONNECT_NUM-1:0]         SLAVE_RECEIVE_ADDR,
  input  logic [CONNECT_NUM-1:0]                    SLAVE_RECEIVE_DATA_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0]         SLAVE_RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]                    SLAVE_RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]                    SLAVE_SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0]         SLAVE_SEND_DATA,
  input  logic [CONNECT_NUM-1:0]                    SLAVE_SEND_READY,
  output logic                                      MASTER_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0]                     MASTER_SEND_ADDR,
  output logic                                      MASTER_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0]                     MASTER_SEND_DATA,
  input  logic                                      MASTER_SEND_READY,
  input  logic                                      MASTER_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]                     MASTER_RECEIVE_DATA,
  output logic                                      MASTER_RECEIVE_READY,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      OUTSTANDING,
  output logic                                      ORPHAN_ERR
);

  localparam int IDW = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  logic                  req_vld_q, req_vld_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_wr_q, req_wr_d;
  logic [DATA_WIDTH-1:0] req_dat_q, req_dat_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  orphan_q, orphan_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [IDW-1:0]        id_mem_q [MAX_OUTSTANDING];

  logic                  can_accept, accept, gnt_vld, fifo_ne, rsp_hs;
  logic [IDW-1:0]        gnt_idx, head_id;
  logic [IDW:0]          rr_sum;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic [DATA_WIDTH-1:0] sel_dat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // The in-flight count doubles as the ID FIFO occupancy: both move on accept and response.
  assign fifo_ne    = (cnt_q != '0);
  assign head_id    = id_mem_q[rd_ptr_q];
  assign can_accept = !RST && (!req_vld_q || MASTER_SEND_READY) && (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept     = can_accept && gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    if (ARB_MODE == 1) begin
      for (int i = 0; i < CONNECT_NUM; i++) begin
        if (SLAVE_RECEIVE_ADDR_VALID[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDW'(i);
        end
      end
    end else begin
      // Walk the offsets downwards so the smallest offset from the pointer is the final winner.
      for (int k = CONNECT_NUM - 1; k >= 0; k--) begin
        rr_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
        if (rr_sum >= (IDW+1)'(CONNECT_NUM)) begin
          rr_sum = rr_sum - (IDW+1)'(CONNECT_NUM);
        end
        if (SLAVE_RECEIVE_ADDR_VALID[rr_sum[IDW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_sum[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_dat  = '0;
    SLAVE_RECEIVE_READY = '0;
    SLAVE_SEND_VALID    = '0;
    SLAVE_SEND_DATA     = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_addr = SLAVE_RECEIVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wr   = SLAVE_RECEIVE_DATA_VALID[i];
        sel_dat  = SLAVE_RECEIVE_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        SLAVE_RECEIVE_READY[i] = accept;
      end
      if (!RST && fifo_ne && (head_id == IDW'(i))) begin
        SLAVE_SEND_VALID[i] = MASTER_RECEIVE_VALID;
        SLAVE_SEND_DATA[i*DATA_WIDTH +: DATA_WIDTH] = MASTER_RECEIVE_DATA;
      end
    end
  end

  assign MASTER_RECEIVE_READY = !RST && fifo_ne && SLAVE_SEND_READY[head_id];
  assign rsp_hs               = MASTER_RECEIVE_VALID && MASTER_RECEIVE_READY;

  always_comb begin
    req_vld_d  = req_vld_q;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    req_dat_d  = req_dat_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      req_vld_d  = 1'b1;
      req_addr_d = sel_addr;
      req_wr_d   = sel_wr;
      req_dat_d  = sel_dat;
      if (ARB_MODE == 0) begin
        rr_ptr_d = (gnt_idx == IDW'(CONNECT_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (MASTER_SEND_READY) begin
      req_vld_d = 1'b0;
    end
    cnt_d    = cnt_q + CW'(accept) - CW'(rsp_hs);
    orphan_d = orphan_q || (MASTER_RECEIVE_VALID && !fifo_ne);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
      req_dat_q  <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      orphan_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_q[i] <= '0;
      end
    end else begin
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      req_wr_q   <= req_wr_d;
      req_dat_q  <= req_dat_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      orphan_q   <= orphan_d;
      if (accept) begin
        id_mem_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (rsp_hs) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  assign MASTER_SEND_ADDR_VALID = req_vld_q;
  assign MASTER_SEND_ADDR       = req_addr_q;
  assign MASTER_SEND_DATA_VALID = req_wr_q;
  assign MASTER_SEND_DATA       = req_dat_q;
  assign OUTSTANDING            = cnt_q;
  assign ORPHAN_ERR             = orphan_q;

endmodule

// File: tb/tb_mc_connect_rr.sv
// Bench for mc_connect_rr: directed scenarios plus randomized traffic against a queue-based model.
module tb_mc_connect_rr;
  localparam int AW = 32, DW = 32, N = 4, MAXO = 4, CW = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [N-1:0]    srav = '0, srdv = '0, ssr = '1;
  logic [AW*N-1:0] sra = '0;
  logic [DW*N-1:0] srd = '0;
  logic            msr = 1'b0, mrv = 1'b0;
  logic [DW-1:0]   mrd = '0;

  logic [N-1:0]    srr, ssv, fp_srr, fp_ssv;
  logic [DW*N-1:0] ssd, fp_ssd;
  logic            msav, msdv, mrr, orph, fp_msav, fp_msdv, fp_mrr, fp_orph;
  logic [AW-1:0]   msa, fp_msa;
  logic [DW-1:0]   msd, fp_msd;
  logic [CW-1:0]   outst, fp_outst;

  mc_connect_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N), .MAX_OUTSTANDING(MAXO), .ARB_MODE(0)) dut (
    .CLK(CLK), .RST(RST),
    .SLAVE_RECEIVE_ADDR_VALID(srav), .SLAVE_RECEIVE_ADDR(sra),
    .SLAVE_RECEIVE_DATA_VALID(srdv), .SLAVE_RECEIVE_DATA(srd),
    .SLAVE_RECEIVE_READY(srr), .SLAVE_SEND_VALID(ssv), .SLAVE_SEND_DATA(ssd),
    .SLAVE_SEND_READY(ssr), .MASTER_SEND_ADDR_VALID(msav), .MASTER_SEND_ADDR(msa),
    .MASTER_SEND_DATA_VALID(msdv), .MASTER_SEND_DATA(msd), .MASTER_SEND_READY(msr),
    .MASTER_RECEIVE_VALID(mrv), .MASTER_RECEIVE_DATA(mrd), .MASTER_RECEIVE_READY(mrr),
    .OUTSTANDING(outst), .ORPHAN_ERR(orph));

  // Fixed-priority instance sharing the same stimulus; only checked in the fairness scenario.
  mc_connect_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N), .MAX_OUTSTANDING(MAXO), .ARB_MODE(1)) dut_fp (
    .CLK(CLK), .RST(RST),
    .SLAVE_RECEIVE_ADDR_VALID(srav), .SLAVE_RECEIVE_ADDR(sra),
    .SLAVE_RECEIVE_DATA_VALID(srdv), .SLAVE_RECEIVE_DATA(srd),
    .SLAVE_RECEIVE_READY(fp_srr), .SLAVE_SEND_VALID(fp_ssv), .SLAVE_SEND_DATA(fp_ssd),
    .SLAVE_SEND_READY(ssr), .MASTER_SEND_ADDR_VALID(fp_msav), .MASTER_SEND_ADDR(fp_msa),
    .MASTER_SEND_DATA_VALID(fp_msdv), .MASTER_SEND_DATA(fp_msd), .MASTER_SEND_READY(msr),
    .MASTER_RECEIVE_VALID(mrv), .MASTER_RECEIVE_DATA(mrd), .MASTER_RECEIVE_READY(fp_mrr),
    .OUTSTANDING(fp_outst), .ORPHAN_ERR(fp_orph));

  int n_tests = 0, n_fail = 0;

  // Reference model: issuing-client queue, pending MC request, MC response queue.
  int            idq[$];
  logic [DW-1:0] rq[$];
  int            p = 0;
  bit            mr_vld = 0, mr_wr = 0, orphan = 0;
  logic [AW-1:0] mr_addr = '0;
  logic [DW-1:0] mr_dat = '0;
  int            last_gnt = -1;
  bit            last_rsp = 0;
  int            p_req = 50, p_msr = 50, p_ssr = 50, p_mrv = 50;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mc_data(input logic [AW-1:0] a, input bit wr);
    return wr ? 32'h0 : (a ^ 32'hC3C3_5A5A);
  endfunction

  task automatic chk();
    int cnt, g, c;
    bit can;
    logic [N-1:0] e_srr, e_ssv;
    logic [DW*N-1:0] e_ssd;
    bit e_mrr;
    @(negedge CLK);
    if (RST) begin
      idq.delete(); rq.delete();
      p = 0; mr_vld = 0; mr_wr = 0; mr_addr = '0; mr_dat = '0; orphan = 0;
      last_gnt = -1; last_rsp = 0;
      return;
    end
    cnt = idq.size();
    can = (!mr_vld || msr) && (cnt < MAXO);
    g = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        c = (p + k) % N;
        if (g < 0 && srav[c]) g = c;
      end
    end
    e_srr = '0; e_ssv = '0; e_ssd = '0; e_mrr = 0;
    if (g >= 0) e_srr[g] = 1'b1;
    if (cnt > 0) begin
      e_ssv[idq[0]] = mrv;
      e_ssd[idq[0]*DW +: DW] = mrd;
      e_mrr = ssr[idq[0]];
    end
    check("SLAVE_RECEIVE_READY", srr, e_srr);
    check("MASTER_SEND_ADDR_VALID", msav, mr_vld);
    if (mr_vld) begin
      check("MASTER_SEND_ADDR", msa, mr_addr);
      check("MASTER_SEND_DATA_VALID", msdv, mr_wr);
      check("MASTER_SEND_DATA", msd, mr_dat);
    end
    check("SLAVE_SEND_VALID", ssv, e_ssv);
    check("SLAVE_SEND_DATA", ssd, e_ssd);
    check("MASTER_RECEIVE_READY", mrr, e_mrr);
    check("OUTSTANDING", outst, cnt);
    check("ORPHAN_ERR", orph, orphan);
    if (mr_vld && msr) rq.push_back(mc_data(mr_addr, mr_wr));
    last_rsp = mrv && e_mrr;
    if (last_rsp) begin
      void'(idq.pop_front());
      if (rq.size() > 0) void'(rq.pop_front());
    end
    if (mrv && cnt == 0) orphan = 1;
    if (g >= 0) begin
      idq.push_back(g);
      mr_vld = 1; mr_addr = sra[g*AW +: AW]; mr_wr = srdv[g]; mr_dat = srd[g*DW +: DW];
      p = (g + 1) % N;
    end else if (msr) begin
      mr_vld = 0;
    end
    last_gnt = g;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_auto();
    for (int c = 0; c < N; c++) begin
      if (srav[c] && last_gnt == c) srav[c] = 1'b0;
      if (!srav[c] && $urandom_range(99) < p_req) begin
        srav[c] = 1'b1;
        sra[c*AW +: AW] = $urandom();
        srdv[c] = 1'($urandom_range(1));
        srd[c*DW +: DW] = $urandom();
      end
      ssr[c] = ($urandom_range(99) < p_ssr);
    end
    msr = ($urandom_range(99) < p_msr);
    if (last_rsp) mrv = 1'b0;
    if (!mrv && rq.size() > 0 && $urandom_range(99) < p_mrv) mrv = 1'b1;
    if (mrv && rq.size() > 0) mrd = rq[0];
  endtask

  task automatic idle_inputs();
    srav = '0; srdv = '0; ssr = '1; msr = 1'b1; mrv = 1'b0; mrd = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    chk();
    adv();
    RST = 1'b0;
  endtask

  logic [N-1:0] rr_seq [6];

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    idle_inputs();
    adv();
    do_reset();

    // Reset state
    chk();
    check("rst_ready", srr, 4'b0000);
    check("rst_send_valid", msav, 1'b0);
    check("rst_outstanding", outst, 3'd0);
    check("rst_orphan", orph, 1'b0);
    adv();

    // Single read from client 2
    srav = 4'b0100; sra[2*AW +: AW] = 32'h100; srdv = '0;
    chk(); check("single_ready", srr, 4'b0100); adv();
    srav = '0;
    chk(); check("single_mc_addr", msa, 32'h100); check("single_mc_vld", msav, 1'b1);
    check("single_cnt1", outst, 3'd1); adv();
    mrv = 1'b1; mrd = 32'hDEAD_BEEF;
    chk(); check("single_rsp_vld", ssv, 4'b0100); check("single_rsp_dat", ssd[2*DW +: DW], 32'hDEAD_BEEF); adv();
    mrv = 1'b0;
    chk(); check("single_cnt0", outst, 3'd0); adv();

    // Round-robin fairness, fixed-priority instance in parallel
    do_reset();
    p_req = 100; p_msr = 100; p_ssr = 100; p_mrv = 100;
    for (int i = 0; i < 6; i++) begin
      drive_auto();
      chk();
      check("rr_grant", srr, rr_seq[i]);
      if (i < 3) check("fp_grant", fp_srr, 4'b1000);
      if (i == 1) begin
        check("fp_mc_addr", fp_msa, sra[3*AW +: AW]);
        check("fp_mc_vld", fp_msav, 1'b1);
        check("fp_cnt1", fp_outst, 3'd1);
      end
      if (i == 2) begin
        check("fp_rsp_vld", fp_ssv, 4'b1000);
        check("fp_rsp_dat", fp_ssd[3*DW +: DW], mrd);
        check("fp_rsp_rdy", fp_mrr, 1'b1);
        check("fp_wr", fp_msdv, srdv[3]);
        check("fp_wdat", fp_msd, srd[3*DW +: DW]);
        check("fp_orphan", fp_orph, 1'b0);
      end
      adv();
    end

    // Outstanding limit
    do_reset();
    p_req = 100; p_msr = 100; p_ssr = 100; p_mrv = 0;
    for (int i = 0; i < 4; i++) begin
      drive_auto(); chk(); check("lim_accept", $countones(srr), 1); adv();
    end
    drive_auto(); chk(); check("lim_full_rdy", srr, 4'b0000); check("lim_full_cnt", outst, 3'd4); adv();
    p_mrv = 100;
    drive_auto(); chk(); check("lim_pop_rdy", srr, 4'b0000); check("lim_pop_mrr", mrr, 1'b1); adv();
    p_mrv = 0;
    drive_auto(); chk(); check("lim_cnt3", outst, 3'd3); check("lim_reaccept", $countones(srr), 1); adv();
    drive_auto(); chk(); check("lim_refull", outst, 3'd4); check("lim_refull_rdy", srr, 4'b0000); adv();

    // Ordering and routing
    do_reset();
    srav = 4'b0010; sra[1*AW +: AW] = 32'h10;
    chk(); check("ord_g1", srr, 4'b0010); adv();
    srav = 4'b1000; sra[3*AW +: AW] = 32'h20;
    chk(); check("ord_g3", srr, 4'b1000); check("ord_a10", msa, 32'h10); adv();
    srav = 4'b0010; sra[1*AW +: AW] = 32'h30;
    chk(); check("ord_g1b", srr, 4'b0010); check("ord_a20", msa, 32'h20); adv();
    srav = '0; mrv = 1'b1; mrd = 32'hAAAA_0001;
    chk(); check("ord_rA", ssv, 4'b0010); check("ord_dA", ssd[1*DW +: DW], 32'hAAAA_0001); check("ord_a30", msa, 32'h30); adv();
    mrd = 32'hBBBB_0002;
    chk(); check("ord_rB", ssv, 4'b1000); check("ord_dB", ssd[3*DW +: DW], 32'hBBBB_0002); adv();
    mrd = 32'hCCCC_0003;
    chk(); check("ord_rC", ssv, 4'b0010); check("ord_dC", ssd[1*DW +: DW], 32'hCCCC_0003); adv();
    mrv = 1'b0;
    chk(); check("ord_cnt0", outst, 3'd0); adv();

    // Response backpressure at the head client
    srav = 4'b0010; sra[1*AW +: AW] = 32'h40;
    chk(); adv();
    srav = '0;
    chk(); adv();
    mrv = 1'b1; mrd = 32'h1234_5678; ssr = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      chk(); check("bp_mrr_low", mrr, 1'b0); check("bp_vld", ssv, 4'b0010);
      check("bp_dat", ssd[1*DW +: DW], 32'h1234_5678); check("bp_cnt", outst, 3'd1); adv();
    end
    ssr = '1;
    chk(); check("bp_release", mrr, 1'b1); adv();
    mrv = 1'b0;
    chk(); check("bp_cnt0", outst, 3'd0); adv();

    // Orphan response
    mrv = 1'b1; mrd = 32'h0000_0BAD;
    chk(); check("orph_vld", ssv, 4'b0000); check("orph_mrr", mrr, 1'b0); adv();
    mrv = 1'b0;
    chk(); check("orph_set", orph, 1'b1); adv();

    // Reset with three requests in flight
    p_req = 100; p_msr = 100; p_ssr = 100; p_mrv = 0;
    for (int i = 0; i < 3; i++) begin
      drive_auto(); chk(); adv();
    end
    idle_inputs();
    chk(); check("mid_cnt3", outst, 3'd3); adv();
    do_reset();
    chk();
    check("post_rst_zero", {srr, ssv, ssd, msav, msa, msdv, msd, mrr, outst, orph}, '0);
    adv();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        p_req = $urandom_range(100, 20); p_msr = $urandom_range(100, 10);
        p_ssr = $urandom_range(100, 10); p_mrv = $urandom_range(100, 10);
      end
      drive_auto(); chk(); adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
